// File: rtl/bcd_scan_driver.sv
// Feeds a 4-digit 7-segment decoder. It accepts a 16-bit value over VALID/READY and
// converts it to BCD by shift-add-3, or passes it through as hex. It then scans the
// four digit slots at a fixed prescaled rate.
module bcd_scan_driver #(
  parameter int unsigned DIV_MAX = 12500
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] DIN,
  input  logic        HEX_MODE,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic        UPD_PULSE,
  output logic [3:0]  BCD,
  output logic [1:0]  SEL_IN
);

  localparam int unsigned PW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic [31:0]   shreg;
  logic [31:0]   adj;
  logic [3:0]    bit_cnt;
  logic [15:0]   disp;
  logic [PW-1:0] presc;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    DIN_READY = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) begin
          accept = 1'b1;
          if (HEX_MODE || (DIN > 16'd9999)) state_nxt = UPDATE;
          else                              state_nxt = CONV;
        end
      end
      CONV:    if (bit_cnt == 4'd15) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    adj = shreg;
    for (int unsigned i = 0; i < 4; i++) begin
      if (shreg[16 + 4*i +: 4] >= 4'd5)
        adj[16 + 4*i +: 4] = shreg[16 + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath and display register. The hex and overflow results are parked
  // in the upper half of the shift register, so UPDATE always copies shreg[31:16].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      disp      <= '0;
      UPD_PULSE <= 1'b0;
    end else begin
      UPD_PULSE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bit_cnt <= '0;
            if (HEX_MODE)            shreg <= {DIN, 16'h0000};
            else if (DIN > 16'd9999) shreg <= {16'hEEEE, 16'h0000};
            else                     shreg <= {16'h0000, DIN};
          end
        end
        CONV: begin
          shreg   <= adj << 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
        UPDATE: begin
          disp      <= shreg[31:16];
          UPD_PULSE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running slot prescaler and digit select, independent of the FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc  <= '0;
      SEL_IN <= '0;
    end else if (presc == DIV_LAST) begin
      presc  <= '0;
      SEL_IN <= SEL_IN + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Digit mux, driven from registers only
  always_comb begin
    BCD = disp[{SEL_IN, 2'b00} +: 4];
  end

endmodule
